// File: rtl/pry2oht_pkg.sv
// Shared types and helpers for the priority-to-one-hot serializer family.
// Holds the FSM state type, direction selectors and the one-hot to binary encoder.
package pry2oht_pkg;

  typedef enum logic {
    IDLE,
    BUSY
  } state_e;

  localparam string DIR_LSB = "LSB";
  localparam string DIR_MSB = "MSB";

  localparam int OHT_MAXW   = 256;
  localparam int OHT_MAXLOG = 8;

  // Each index bit is the OR of every one-hot position whose index has that bit set.
  function automatic logic [OHT_MAXLOG-1:0] oht2bin(input logic [OHT_MAXW-1:0] oht);
    logic [OHT_MAXLOG-1:0] bin;
    bin = '0;
    for (int b = 0; b < OHT_MAXLOG; b++) begin
      for (int k = 0; k < OHT_MAXW; k++) begin
        if (k[b]) begin
          bin[b] = bin[b] | oht[k];
        end
      end
    end
    return bin;
  endfunction

endpackage

// File: rtl/pry2oht_bck.sv
// Priority-to-one-hot as a backward tree: group-valid flows up, grant enable flows down.
// Purely combinational; ena gates every output bit so a disabled subtree grants nothing.
module pry2oht_bck
  import pry2oht_pkg::*;
#(
  parameter int    WIDTH     = 9,
  parameter int    SPLIT     = 3,
  parameter string DIRECTION = DIR_LSB
) (
  input  logic             ena,
  input  logic [WIDTH-1:0] pry,
  output logic [WIDTH-1:0] oht,
  output logic             vld
);

  localparam bit MSB_FIRST = (DIRECTION == DIR_MSB);

  if (WIDTH <= SPLIT) begin : g_leaf
    logic found;
    always_comb begin
      oht   = '0;
      found = 1'b0;
      for (int k = 0; k < WIDTH; k++) begin
        if (!MSB_FIRST && !found && pry[k]) begin
          oht[k] = ena;
          found  = 1'b1;
        end
        if (MSB_FIRST && !found && pry[WIDTH-1-k]) begin
          oht[WIDTH-1-k] = ena;
          found          = 1'b1;
        end
      end
    end
    assign vld = |pry;
  end else begin : g_node
    localparam int GSZ  = (WIDTH + SPLIT - 1) / SPLIT;
    localparam int NGRP = (WIDTH + GSZ - 1) / GSZ;

    logic [NGRP-1:0] grp_vld;
    logic [NGRP-1:0] grp_ena;
    logic            taken;

    // Only the first non-empty group in priority order keeps the enable.
    always_comb begin
      grp_ena = '0;
      taken   = 1'b0;
      for (int g = 0; g < NGRP; g++) begin
        if (!MSB_FIRST) begin
          grp_ena[g] = ena & ~taken;
          taken      = taken | grp_vld[g];
        end else begin
          grp_ena[NGRP-1-g] = ena & ~taken;
          taken             = taken | grp_vld[NGRP-1-g];
        end
      end
    end

    for (genvar g = 0; g < NGRP; g++) begin : g_sub
      localparam int LO = g * GSZ;
      localparam int SW = (g == NGRP - 1) ? (WIDTH - LO) : GSZ;
      pry2oht_bck #(
        .WIDTH     (SW),
        .SPLIT     (SPLIT),
        .DIRECTION (DIRECTION)
      ) u_sub (
        .ena (grp_ena[g]),
        .pry (pry[LO +: SW]),
        .oht (oht[LO +: SW]),
        .vld (grp_vld[g])
      );
    end

    assign vld = |grp_vld;
  end

endmodule

// File: rtl/pry2oht_ser.sv
// Serializes an accepted request vector into one grant beat per set bit, in priority order.
// First beat one cycle after acceptance; outputs hold while o_rdy is low; last beat overlaps next accept.
module pry2oht_ser
  import pry2oht_pkg::*;
#(
  parameter  int    WIDTH     = 9,
  parameter  int    SPLIT     = 3,
  parameter  string DIRECTION = DIR_LSB,
  localparam int    WIDTHLOG  = $clog2(WIDTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_vld,
  output logic                i_rdy,
  input  logic [WIDTH-1:0]    i_pry,
  output logic                o_vld,
  input  logic                o_rdy,
  output logic [WIDTH-1:0]    o_oht,
  output logic [WIDTHLOG-1:0] o_bin,
  output logic                o_lst,
  output logic                o_zro
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             zro_q, zro_d;
  logic [WIDTH-1:0] sel_oht;
  logic             rem_vld_unused;
  logic             busy;

  pry2oht_bck #(
    .WIDTH     (WIDTH),
    .SPLIT     (SPLIT),
    .DIRECTION (DIRECTION)
  ) u_bck (
    .ena (1'b1),
    .pry (rem_q),
    .oht (sel_oht),
    .vld (rem_vld_unused)
  );

  assign busy  = (state_q == BUSY);
  assign o_vld = busy;
  assign o_oht = busy ? sel_oht : '0;
  assign o_bin = busy ? WIDTHLOG'(oht2bin(OHT_MAXW'(sel_oht))) : '0;
  assign o_lst = busy & ~|(rem_q & ~sel_oht);
  assign o_zro = busy & zro_q;
  assign i_rdy = ~busy | (o_vld & o_rdy & o_lst);

  // A new vector accepted alongside the last beat overrides the drain update.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    zro_d   = zro_q;
    if (o_vld && o_rdy) begin
      rem_d = rem_q & ~sel_oht;
      if (o_lst) begin
        state_d = IDLE;
      end
    end
    if (i_vld && i_rdy) begin
      rem_d   = i_pry;
      zro_d   = ~|i_pry;
      state_d = BUSY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      zro_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      zro_q   <= zro_d;
    end
  end

endmodule

// File: tb/tb_pry2oht_ser.sv
// Drives an LSB-first and an MSB-first serializer with identical stimulus and
// checks both against per-direction queues of expected grant indices.
module tb_pry2oht_ser;

  localparam int W  = 9;
  localparam int WL = 4;

  logic          clk = 1'b0;
  logic          rst, i_vld, o_rdy;
  logic [W-1:0]  i_pry;

  logic          l_irdy, l_ovld, l_lst, l_zro;
  logic [W-1:0]  l_oht;
  logic [WL-1:0] l_bin;
  logic          m_irdy, m_ovld, m_lst, m_zro;
  logic [W-1:0]  m_oht;
  logic [WL-1:0] m_bin;

  int total = 0;
  int bad   = 0;
  int ql[$];
  int qm[$];
  bit armed = 1'b0;

  always #5 clk = ~clk;

  pry2oht_ser #(.WIDTH(W), .SPLIT(3), .DIRECTION("LSB")) u_lsb (
    .clk(clk), .rst(rst), .i_vld(i_vld), .i_rdy(l_irdy), .i_pry(i_pry),
    .o_vld(l_ovld), .o_rdy(o_rdy), .o_oht(l_oht), .o_bin(l_bin),
    .o_lst(l_lst), .o_zro(l_zro)
  );

  pry2oht_ser #(.WIDTH(W), .SPLIT(3), .DIRECTION("MSB")) u_msb (
    .clk(clk), .rst(rst), .i_vld(i_vld), .i_rdy(m_irdy), .i_pry(i_pry),
    .o_vld(m_ovld), .o_rdy(o_rdy), .o_oht(m_oht), .o_bin(m_bin),
    .o_lst(m_lst), .o_zro(m_zro)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected grant order: set-bit indices ascending (LSB) or descending (MSB); -1 marks an empty vector.
  task automatic load(input logic [W-1:0] v);
    if (v == '0) begin
      ql.push_back(-1);
      qm.push_back(-1);
    end else begin
      for (int i = 0; i < W; i++) if (v[i]) ql.push_back(i);
      for (int i = W - 1; i >= 0; i--) if (v[i]) qm.push_back(i);
    end
  endtask

  task automatic chk_side(input string s, input int front, input int n, input logic ordy,
                          input logic vld, input logic irdy, input logic [W-1:0] oht,
                          input logic [WL-1:0] bin, input logic lst, input logic zro);
    bit            busy;
    logic [W-1:0]  eo;
    logic [WL-1:0] eb;
    busy = (n > 0);
    eo   = (busy && front >= 0) ? (W'(1) << front) : '0;
    eb   = (busy && front >= 0) ? WL'(front) : '0;
    chk({s, ".o_vld"}, 32'(vld), 32'(busy));
    chk({s, ".o_oht"}, 32'(oht), 32'(eo));
    chk({s, ".o_bin"}, 32'(bin), 32'(eb));
    chk({s, ".o_lst"}, 32'(lst), 32'(n == 1));
    chk({s, ".o_zro"}, 32'(zro), 32'(busy && front < 0));
    chk({s, ".i_rdy"}, 32'(irdy), 32'(!busy || (ordy && n == 1)));
  endtask

  task automatic cycle(input logic r, input logic v, input logic [W-1:0] p, input logic ordy);
    bit erdy;
    rst   = r;
    i_vld = v;
    i_pry = p;
    o_rdy = ordy;
    @(negedge clk);
    erdy = (ql.size() == 0) || (ordy && ql.size() == 1);
    if (armed) begin
      chk_side("lsb", (ql.size() > 0) ? ql[0] : 0, ql.size(), ordy,
               l_ovld, l_irdy, l_oht, l_bin, l_lst, l_zro);
      chk_side("msb", (qm.size() > 0) ? qm[0] : 0, qm.size(), ordy,
               m_ovld, m_irdy, m_oht, m_bin, m_lst, m_zro);
    end
    @(posedge clk);
    #1;
    if (r) begin
      ql.delete();
      qm.delete();
      armed = 1'b1;
    end else begin
      if (ordy && ql.size() > 0) begin
        void'(ql.pop_front());
        void'(qm.pop_front());
      end
      if (v && erdy) load(p);
    end
  endtask

  function automatic logic [W-1:0] junk();
    return W'($urandom);
  endfunction

  initial begin
    logic [W-1:0] p;
    int mode;

    // Reset with a valid full vector presented: nothing may be captured.
    cycle(1'b1, 1'b1, 9'h1FF, 1'b1);
    cycle(1'b1, 1'b1, 9'h1FF, 1'b1);
    cycle(1'b0, 1'b0, junk(), 1'b1);

    // Sparse vector: LSB grants 2,5,8 and MSB grants 8,5,2.
    cycle(1'b0, 1'b1, 9'b1_0010_0100, 1'b1);
    repeat (3) cycle(1'b0, 1'b0, junk(), 1'b1);
    cycle(1'b0, 1'b0, junk(), 1'b1);

    // Empty vector yields exactly one zero beat.
    cycle(1'b0, 1'b1, 9'h000, 1'b1);
    cycle(1'b0, 1'b0, junk(), 1'b1);
    cycle(1'b0, 1'b0, junk(), 1'b1);

    // Stalled first beat must hold stable.
    cycle(1'b0, 1'b1, 9'h003, 1'b1);
    repeat (3) cycle(1'b0, 1'b0, junk(), 1'b0);
    repeat (3) cycle(1'b0, 1'b0, junk(), 1'b1);

    // Back-to-back vectors with i_vld held high.
    cycle(1'b0, 1'b1, 9'h180, 1'b1);
    cycle(1'b0, 1'b1, 9'h001, 1'b1);
    cycle(1'b0, 1'b1, 9'h001, 1'b1);
    cycle(1'b0, 1'b0, junk(), 1'b1);
    cycle(1'b0, 1'b0, junk(), 1'b1);

    // Reset in the middle of a full vector.
    cycle(1'b0, 1'b1, 9'h1FF, 1'b1);
    repeat (3) cycle(1'b0, 1'b0, junk(), 1'b1);
    cycle(1'b1, 1'b0, junk(), 1'b1);
    cycle(1'b0, 1'b1, 9'h010, 1'b1);
    cycle(1'b0, 1'b0, junk(), 1'b1);
    cycle(1'b0, 1'b0, junk(), 1'b1);

    // Full-ones vector with random backpressure.
    cycle(1'b0, 1'b1, 9'h1FF, 1'b1);
    repeat (14) cycle(1'b0, 1'b0, junk(), 1'($urandom_range(0, 1)));

    for (int n = 0; n < 2000; n++) begin
      mode = $urandom_range(0, 7);
      if (mode == 0)      p = '0;
      else if (mode == 1) p = W'(1) << $urandom_range(0, W - 1);
      else                p = junk();
      cycle(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 2) != 0), p,
            1'($urandom_range(0, 3) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
